collision_scheduler: RTL and testbench

COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

---
 rtl/collision_scheduler.sv | 170 +++++++++++++++++
 tb/tb_collision_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : collision_scheduler
// Description : Walks every (player, platform) pair once per frame through an
//               external collision resolver and commits the resolved results.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_scheduler #(
    parameter int NP      = 2,
    parameter int NPL     = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_tick,
    input  logic [NP*10-1:0]              px_in,
    input  logic [NP*10-1:0]              py_in,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic [((NP > 1) ? $clog2(NP) : 1)-1:0]   req_player,
    output logic [((NPL > 1) ? $clog2(NPL) : 1)-1:0] req_plat,
    output logic signed [9:0]             req_x,
    output logic signed [9:0]             req_y,
    input  logic                          rsp_valid,
    input  logic                          rsp_hit,
    input  logic signed [9:0]             rsp_x,
    input  logic signed [9:0]             rsp_y,
    output logic [NP*10-1:0]              px_out,
    output logic [NP*10-1:0]              py_out,
    output logic [NP*NPL-1:0]             hit_mask,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun,
    output logic                          timeout_err
);

    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int FW = (NPL > 1) ? $clog2(NPL) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] c_LAST_PL = PW'(NP - 1);
    localparam logic [FW-1:0] c_LAST_PF = FW'(NPL - 1);
    localparam logic [TW-1:0] c_LAST_T  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_pl;
    logic [FW-1:0]         r_pf;
    logic [TW-1:0]         r_timer;
    logic signed [9:0]     r_wx [NP];
    logic signed [9:0]     r_wy [NP];
    logic [NPL-1:0]        r_wmask [NP];
    logic                  r_req_valid;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_overrun;
    logic                  r_timeout_err;
    logic [NP*10-1:0]      r_px_out;
    logic [NP*10-1:0]      r_py_out;
    logic [NP*NPL-1:0]     r_hit_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pl          <= '0;
            r_pf          <= '0;
            r_timer       <= '0;
            r_req_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_px_out      <= '0;
            r_py_out      <= '0;
            r_hit_mask    <= '0;
            for (int i = 0; i < NP; i++) begin
                r_wx[i]    <= '0;
                r_wy[i]    <= '0;
                r_wmask[i] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            if (frame_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        for (int i = 0; i < NP; i++) begin
                            r_wx[i]    <= px_in[i*10 +: 10];
                            r_wy[i]    <= py_in[i*10 +: 10];
                            r_wmask[i] <= '0;
                        end
                        r_pl        <= '0;
                        r_pf        <= '0;
                        r_req_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A response arriving alongside the handshake is dropped
                    if (req_ready) begin
                        r_req_valid <= 1'b0;
                        r_timer     <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid || (r_timer == c_LAST_T)) begin
                        if (rsp_valid && rsp_hit) begin
                            r_wx[r_pl]          <= rsp_x;
                            r_wy[r_pl]          <= rsp_y;
                            r_wmask[r_pl][r_pf] <= 1'b1;
                        end
                        if (!rsp_valid) begin
                            r_timeout_err <= 1'b1;
                        end
                        if ((r_pf == c_LAST_PF) && (r_pl == c_LAST_PL)) begin
                            r_pf    <= '0;
                            r_state <= S_DONE;
                        end else begin
                            if (r_pf == c_LAST_PF) begin
                                r_pf <= '0;
                                r_pl <= r_pl + 1'b1;
                            end else begin
                                r_pf <= r_pf + 1'b1;
                            end
                            r_req_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE: begin
                    for (int i = 0; i < NP; i++) begin
                        r_px_out[i*10 +: 10]    <= r_wx[i];
                        r_py_out[i*10 +: 10]    <= r_wy[i];
                        r_hit_mask[i*NPL +: NPL] <= r_wmask[i];
                    end
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_valid   = r_req_valid;
    assign req_player  = r_pl;
    assign req_plat    = r_pf;
    assign req_x       = r_wx[r_pl];
    assign req_y       = r_wy[r_pl];
    assign px_out      = r_px_out;
    assign py_out      = r_py_out;
    assign hit_mask    = r_hit_mask;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_collision_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_scheduler
// Description : Directed self-checking bench for collision_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_scheduler;

    logic              clk;
    logic              rst_n;
    logic              frame_tick;
    logic [19:0]       px_in;
    logic [19:0]       py_in;
    logic              req_valid;
    logic              req_ready;
    logic [0:0]        req_player;
    logic [1:0]        req_plat;
    logic signed [9:0] req_x;
    logic signed [9:0] req_y;
    logic              rsp_valid;
    logic              rsp_hit;
    logic signed [9:0] rsp_x;
    logic signed [9:0] rsp_y;
    logic [19:0]       px_out;
    logic [19:0]       py_out;
    logic [7:0]        hit_mask;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    collision_scheduler #(.NP(2), .NPL(4), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .px_in       (px_in),
        .py_in       (py_in),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_player  (req_player),
        .req_plat    (req_plat),
        .req_x       (req_x),
        .req_y       (req_y),
        .rsp_valid   (rsp_valid),
        .rsp_hit     (rsp_hit),
        .rsp_x       (rsp_x),
        .rsp_y       (rsp_y),
        .px_out      (px_out),
        .py_out      (py_out),
        .hit_mask    (hit_mask),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!req_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_valid_seen", 32'(req_valid), 32'd1);
    endtask

    // mode: 0 miss, 1 hit, 2 no response, 3 junk response at handshake then miss
    task automatic do_pair(input int ep, input int ef,
                           input logic signed [9:0] ex, input logic signed [9:0] ey,
                           input int bp, input int mode,
                           input logic signed [9:0] rx, input logic signed [9:0] ry);
        wait_req();
        chk("req_player", 32'(req_player), 32'(ep));
        chk("req_plat", 32'(req_plat), 32'(ef));
        chk("req_x", 32'(req_x), 32'(ex));
        chk("req_y", 32'(req_y), 32'(ey));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_req", 32'({req_valid, req_player, req_plat, req_x, req_y}),
                32'({1'b1, ep[0], ef[1:0], ex, ey}));
        end
        req_ready = 1'b1;
        if (mode == 3) begin
            rsp_valid = 1'b1;
            rsp_hit   = 1'b1;
            rsp_x     = 10'sd99;
            rsp_y     = 10'sd99;
        end
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_hit   = 1'b0;
        chk("wait_valid", 32'(req_valid), 32'd0);
        if (mode == 2) begin
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                chk("to_wait", 32'({req_valid, timeout_err}), 32'd0);
            end
            @(negedge clk);
            chk("to_advance", 32'({req_valid, timeout_err}), 32'd3);
        end else begin
            @(negedge clk);
            rsp_valid = 1'b1;
            rsp_hit   = (mode == 1);
            rsp_x     = rx;
            rsp_y     = ry;
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_hit   = 1'b0;
        end
    endtask

    task automatic start_frame(input logic signed [9:0] x0, input logic signed [9:0] y0,
                               input logic signed [9:0] x1, input logic signed [9:0] y1);
        px_in      = {x1, x0};
        py_in      = {y1, y0};
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("busy_start", 32'({busy, req_valid}), 32'd3);
    endtask

    task automatic run_miss_frame(input logic signed [9:0] x0, input logic signed [9:0] y0,
                                  input logic signed [9:0] x1, input logic signed [9:0] y1);
        start_frame(x0, y0, x1, y1);
        for (int p = 0; p < 2; p++) begin
            for (int f = 0; f < 4; f++) begin
                do_pair(p, f, (p == 0) ? x0 : x1, (p == 0) ? y0 : y1, 0, 0, 10'sd0, 10'sd0);
            end
        end
    endtask

    task automatic wait_done(input logic signed [9:0] x0, input logic signed [9:0] y0,
                             input logic signed [9:0] x1, input logic signed [9:0] y1,
                             input logic [7:0] m);
        int n = 0;
        while (!frame_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("px_out", 32'(px_out), 32'({x1, x0}));
        chk("py_out", 32'(py_out), 32'({y1, y0}));
        chk("hit_mask", 32'(hit_mask), 32'(m));
        chk("busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(frame_done), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        px_in      = '0;
        py_in      = '0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_hit    = 1'b0;
        rsp_x      = '0;
        rsp_y      = '0;
        repeat (2) @(negedge clk);
        chk("rst_flags", 32'({req_valid, busy, frame_done, overrun, timeout_err}), 32'd0);
        chk("rst_pos", 32'({px_out, py_out}), 32'd0);
        chk("rst_mask", 32'(hit_mask), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 1: every pair misses
        run_miss_frame(10'sd10, 10'sd20, 10'sd50, 10'sd20);
        wait_done(10'sd10, 10'sd20, 10'sd50, 10'sd20, 8'h00);
        chk("f1_sticky", 32'({overrun, timeout_err}), 32'd0);

        // Frame 2: overrun, backpressure, chained hits, timeout
        start_frame(-10'sd3, 10'sd7, 10'sd100, -10'sd200);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("overrun", 32'(overrun), 32'd1);
        do_pair(0, 0, -10'sd3, 10'sd7, 5, 0, 10'sd0, 10'sd0);
        do_pair(0, 1, -10'sd3, 10'sd7, 0, 1, 10'sd11, -10'sd5);
        do_pair(0, 2, 10'sd11, -10'sd5, 0, 1, 10'sd12, -10'sd6);
        do_pair(0, 3, 10'sd12, -10'sd6, 0, 0, 10'sd0, 10'sd0);
        do_pair(1, 0, 10'sd100, -10'sd200, 0, 2, 10'sd0, 10'sd0);
        chk("px_hold", 32'(px_out), 32'({10'sd50, 10'sd10}));
        chk("mask_hold", 32'(hit_mask), 32'd0);
        do_pair(1, 1, 10'sd100, -10'sd200, 0, 1, 10'sd1, 10'sd2);
        do_pair(1, 2, 10'sd1, 10'sd2, 0, 0, 10'sd0, 10'sd0);
        do_pair(1, 3, 10'sd1, 10'sd2, 0, 0, 10'sd0, 10'sd0);
        wait_done(10'sd12, -10'sd6, 10'sd1, 10'sd2, 8'h26);
        chk("f2_sticky", 32'({overrun, timeout_err}), 32'd3);

        // Frame 3: response during handshake is dropped, then reset mid-WAIT
        start_frame(10'sd5, 10'sd6, 10'sd7, 10'sd8);
        do_pair(0, 0, 10'sd5, 10'sd6, 0, 3, 10'sd0, 10'sd0);
        wait_req();
        chk("junk_ignored", 32'({req_plat, req_x, req_y}), 32'({2'd1, 10'sd5, 10'sd6}));
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("mid_wait", 32'({req_valid, busy}), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_flags", 32'({req_valid, busy, frame_done, overrun, timeout_err}), 32'd0);
        chk("arst_pos", 32'({px_out, py_out}), 32'd0);
        chk("arst_mask", 32'(hit_mask), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'({busy, frame_done, req_valid}), 32'd0);

        // Frame 4: clean restart from pair (0,0)
        run_miss_frame(10'sd30, 10'sd40, -10'sd60, 10'sd70);
        wait_done(10'sd30, 10'sd40, -10'sd60, 10'sd70, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
